// File: rtl/shift_add_mul_ctrl.sv
// rtl/shift_add_mul_ctrl.sv - shift-and-add multiply controller driving an external ripple adder
// One adder pass per RUN cycle; the carry-out becomes the top bit of the shifted accumulator.
module shift_add_mul_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     adder_a,
  output logic [WIDTH-1:0]     adder_b,
  input  logic [WIDTH-1:0]     adder_sum,
  input  logic                 adder_cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]       state;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    count;
  logic [2*WIDTH-1:0] next_acc;
  logic             last_iter;

  // Sum plus carry, shifted right by one together with the low half.
  assign next_acc  = {adder_cout, adder_sum, lo[WIDTH-1:1]};
  assign last_iter = (count == CW'(WIDTH - 1));

  assign adder_a = hi;
  assign adder_b = ((state == ST_RUN) && lo[0]) ? m_reg : '0;
  assign busy    = (state == ST_RUN) || (state == ST_DONE);
  assign done    = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      m_reg   <= '0;
      hi      <= '0;
      lo      <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            hi    <= '0;
            lo    <= multiplier;
            count <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          {hi, lo} <= next_acc;
          count    <= count + 1'b1;
          if (last_iter) begin
            product <= next_acc;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// tb/tb_shift_add_mul_ctrl.sv - directed and random checks of shift_add_mul_ctrl
module tb_shift_add_mul_ctrl;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   adder_a;
  logic [W-1:0]   adder_b;
  logic [W-1:0]   adder_sum;
  logic           adder_cout;
  logic [W:0]     add_res;

  int total;
  int bad;
  bit cout_seen;

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[11];

  // Stand-in for the external ripple adder, carry-in tied low.
  assign add_res    = {1'b0, adder_a} + {1'b0, adder_b};
  assign adder_sum  = add_res[W-1:0];
  assign adder_cout = add_res[W];

  shift_add_mul_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .busy(busy),
    .done(done),
    .product(product),
    .adder_a(adder_a),
    .adder_b(adder_b),
    .adder_sum(adder_sum),
    .adder_cout(adder_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until done is seen, returning the number of edges taken.
  task automatic wait_done(input string name, output int edges);
    edges = 0;
    while (!done && edges < 40) begin
      step();
      edges++;
    end
    if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // One complete multiply from IDLE, checking the adder operands each RUN cycle.
  task automatic do_mul(input string name, input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [2*W-1:0] exp);
    logic [W-1:0] mh, ml, b;
    logic [W:0]   s;
    cout_seen    = 1'b0;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    step();
    start        = 1'b0;
    multiplicand = ~m;
    multiplier   = ~q;
    mh = '0;
    ml = q;
    for (int i = 0; i < W; i++) begin
      b = ml[0] ? m : '0;
      chk({name, "_busy_run"}, 32'(busy), 32'd1);
      chk({name, "_done_early"}, 32'(done), 32'd0);
      chk({name, "_adder_a"}, 32'(adder_a), 32'(mh));
      chk({name, "_adder_b"}, 32'(adder_b), 32'(b));
      if (adder_cout) cout_seen = 1'b1;
      s = {1'b0, mh} + {1'b0, b};
      {mh, ml} = {s, ml[W-1:1]};
      step();
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_busy_done"}, 32'(busy), 32'd1);
    chk({name, "_product"}, 32'(product), 32'(exp));
    step();
    chk({name, "_done_clear"}, 32'(done), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
    chk({name, "_product_hold"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int n1, n2;
    logic [W-1:0] rm, rq;
    total = 0;
    bad   = 0;

    vecs[0]  = '{8'h0D, 8'h0B, 16'h008F};
    vecs[1]  = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2]  = '{8'h00, 8'hFF, 16'h0000};
    vecs[3]  = '{8'h80, 8'h02, 16'h0100};
    vecs[4]  = '{8'h03, 8'h05, 16'h000F};
    vecs[5]  = '{8'h12, 8'h34, 16'h03A8};
    vecs[6]  = '{8'h01, 8'h01, 16'h0001};
    vecs[7]  = '{8'hFF, 8'h01, 16'h00FF};
    vecs[8]  = '{8'h10, 8'h10, 16'h0100};
    vecs[9]  = '{8'hAA, 8'h55, 16'h3872};
    vecs[10] = '{8'h7F, 8'h81, 16'h3FFF};

    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_adder_a", 32'(adder_a), 32'd0);
    chk("rst_adder_b", 32'(adder_b), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      do_mul($sformatf("vec%0d", i), vecs[i].m, vecs[i].q, vecs[i].p);
      if (i == 1) chk("ffxff_cout_seen", 32'(cout_seen), 32'd1);
    end

    // Back-to-back with start held; operands change during RUN and must be ignored.
    multiplicand = 8'h00;
    multiplier   = 8'hFF;
    start        = 1'b1;
    step();
    multiplicand = 8'h80;
    multiplier   = 8'h02;
    wait_done("b2b_first", n1);
    chk("b2b_first_latency", 32'(n1), 32'd8);
    chk("b2b_first_product", 32'(product), 32'h0000);
    step();
    wait_done("b2b_second", n2);
    chk("b2b_gap", 32'(n2 + 1), 32'd10);
    chk("b2b_second_product", 32'(product), 32'h0100);
    start = 1'b0;
    step();
    chk("b2b_idle", 32'(busy), 32'd0);

    // Start pulse on RUN cycle 3 must not disturb the running multiply.
    multiplicand = 8'h03;
    multiplier   = 8'h05;
    start        = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    start        = 1'b1;
    multiplicand = 8'hAA;
    multiplier   = 8'h55;
    step();
    start = 1'b0;
    wait_done("ign", n1);
    chk("ign_latency", 32'(n1 + 3), 32'd8);
    chk("ign_product", 32'(product), 32'h000F);
    step();
    chk("ign_idle", 32'(busy), 32'd0);
    step();
    chk("ign_no_restart", 32'(busy), 32'd0);

    // Reset during RUN cycle 4 clears everything without a done pulse.
    multiplicand = 8'h12;
    multiplier   = 8'h34;
    start        = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    do_mul("after_rst", 8'h12, 8'h34, 16'h03A8);

    for (int i = 0; i < 256; i++) begin
      rm = 8'($urandom_range(0, 255));
      rq = 8'($urandom_range(0, 255));
      do_mul($sformatf("rnd%0d", i), rm, rq, 16'(rm) * 16'(rq));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
